// File: rtl/store_trace_if.sv
// Bundle of the store-sampling inputs and the trace-drain handshake for store_trace_buffer.
// The slave modport is the buffer itself; the master modport is the core/debug-host side.
interface store_trace_if #(
    parameter int DEPTH = 8
) ();
    logic                     memwrite;
    logic [31:0]              dataaddr;
    logic [31:0]              writedata;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_addr;
    logic [31:0]              out_data;
    logic [$clog2(DEPTH):0]   count;
    logic                     overflow;
    logic [15:0]              drop_cnt;
    logic                     pass;
    logic                     fail;

    modport slave (
        input  memwrite, dataaddr, writedata, out_ready,
        output out_valid, out_addr, out_data, count, overflow, drop_cnt, pass, fail
    );

    modport master (
        output memwrite, dataaddr, writedata, out_ready,
        input  out_valid, out_addr, out_data, count, overflow, drop_cnt, pass, fail
    );
endinterface

// File: rtl/store_trace_buffer.sv
// Captures every data-memory store as an {addr,data} record in a FIFO drained by valid/ready.
// Optional pass/fail store detector enabled by defining STORE_TRACE_PASS_DETECT_EN.
module store_trace_buffer #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] PASS_ADDR = 32'd84,
    parameter logic [31:0] PASS_DATA = 32'd7
) (
    input  logic          clk,
    input  logic          rst,
    store_trace_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [63:0]   mem [DEPTH];
    logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d, count_q, count_d;
    logic [63:0]   head_q, head_d;
    logic          overflow_q, overflow_d;
    logic [15:0]   drop_q, drop_d;
    logic          empty, full, pop, push_acc, drop;

    assign empty    = (wptr_q == rptr_q);
    assign full     = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign pop      = !empty && bus.out_ready;
    assign push_acc = bus.memwrite && (!full || pop);
    assign drop     = bus.memwrite && full && !pop;

    always_comb begin
        wptr_d     = wptr_q + PW'(push_acc);
        rptr_d     = rptr_q + PW'(pop);
        count_d    = wptr_d - rptr_d;
        overflow_d = overflow_q | drop;
        drop_d     = (drop && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
        // The head register must see a record written into the slot it is about to expose.
        if (push_acc && (wptr_q[AW-1:0] == rptr_d[AW-1:0]))
            head_d = {bus.dataaddr, bus.writedata};
        else
            head_d = mem[rptr_d[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst && push_acc)
            mem[wptr_q[AW-1:0]] <= {bus.dataaddr, bus.writedata};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            head_q     <= '0;
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else begin
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            overflow_q <= overflow_d;
            drop_q     <= drop_d;
        end
    end

    assign bus.out_valid = (count_q != '0);
    assign bus.out_addr  = head_q[63:32];
    assign bus.out_data  = head_q[31:0];
    assign bus.count     = count_q;
    assign bus.overflow  = overflow_q;
    assign bus.drop_cnt  = drop_q;

`ifdef STORE_TRACE_PASS_DETECT_EN
    logic pass_q, fail_q, hit;

    // Dropped stores still count: the verdict depends only on what the core wrote.
    assign hit = bus.memwrite && (bus.dataaddr == PASS_ADDR) && !pass_q && !fail_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pass_q <= 1'b0;
            fail_q <= 1'b0;
        end else if (hit) begin
            pass_q <= (bus.writedata == PASS_DATA);
            fail_q <= (bus.writedata != PASS_DATA);
        end
    end

    assign bus.pass = pass_q;
    assign bus.fail = fail_q;
`else
    assign bus.pass = 1'b0;
    assign bus.fail = 1'b0;
`endif
endmodule

// File: doc/store_trace_buffer.md
# store_trace_buffer

Downstream observer of the single-cycle MIPS core's data-memory port. It samples every store (`memwrite`, `dataaddr`, `writedata`) on the same clock edge the data memory commits it, and queues each store as an {address, data} record in a small FIFO. A simulation bench or debug host drains the FIFO through a valid/ready handshake. An optional detector flags the lab pass condition: a store of `PASS_DATA` to `PASS_ADDR`.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `PASS_ADDR`, 32'd84: byte address watched by the pass/fail detector.
- `PASS_DATA`, 32'd7: value that signals pass when stored to `PASS_ADDR`.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: reset, asynchronous and active-low; clears all state.
- `memwrite`  in  1: store strobe from the core.
- `dataaddr`  in  32: store byte address (core ALU output).
- `writedata`  in  32: store data.
- `out_valid`  out  1: head record available.
- `out_ready`  in  1: consumer accepts the head record this cycle.
- `out_addr`  out  32: head record address.
- `out_data`  out  32: head record data.
- `count`  out  $clog2(DEPTH)+1: current occupancy, 0..DEPTH.
- `overflow`  out  1: sticky; set when a store was dropped.
- `drop_cnt`  out  16: saturating count of dropped stores.
- `pass`  out  1: sticky pass flag (see Configuration).
- `fail`  out  1: sticky fail flag (see Configuration).

## Operation
- Storage is a DEPTH×64 register array. Read and write pointers are $clog2(DEPTH)+1 bits wide, with the extra bit used as the wrap bit.
  - Empty: the pointers are fully equal.
  - Full: the index bits are equal and the wrap bits differ.
- Push condition: `memwrite`=1 at the rising edge. The record {`dataaddr`, `writedata`} is written at `wptr`, and `wptr` increments modulo 2·DEPTH.
- Pop condition: `out_valid`=1 and `out_ready`=1 at the rising edge. `rptr` increments.
- `count` = `wptr` − `rptr` (modular), registered. It changes by +1 on push only, −1 on pop only, and 0 when both occur or neither occurs.
- Full and push without pop:
  - The record is dropped and the pointers are unchanged.
  - `overflow` is set to 1.
  - `drop_cnt` increments, saturating at 16'hFFFF.
- Full and push with pop: both are accepted and `count` stays at DEPTH.
- Empty and push: the record becomes visible the next cycle. There is no same-cycle bypass, so `out_valid` never depends combinationally on `memwrite`.
- `out_ready` while `out_valid`=0 is ignored.
- `out_addr`/`out_data` are driven from the array entry at `rptr`.
  - Their contents are don't-care while `out_valid`=0.
  - They hold stable while `out_valid`=1 and `out_ready`=0.
- `out_valid` = (`count` != 0).
- `overflow` and `drop_cnt` clear only on reset.

## Timing
- Reset values (asynchronous on `rst`=0):
  - `wptr`=`rptr`=0 and `count`=0.
  - `out_valid`=0 and `out_addr`=`out_data`=0.
  - `overflow`=0, `drop_cnt`=0, `pass`=0, `fail`=0.
  - Array contents are not reset.
- Reset asserted mid-operation discards all queued records immediately. A `memwrite` during reset is not captured.
- Push-to-visible latency: 1 cycle. A store at edge N gives `out_valid`=1 after edge N and is poppable at edge N+1.
- Throughput: one push and one pop per cycle, sustained indefinitely with no loss when `out_ready` is held at 1.
- Pointer wrap: after 2·DEPTH pushes the pointers return to 0 with no bubble.

## Configuration
- Macro: `STORE_TRACE_PASS_DETECT_EN`.
- Defined:
  - A store with `dataaddr`==`PASS_ADDR` and `writedata`==`PASS_DATA` sets `pass`.
  - A store with `dataaddr`==`PASS_ADDR` and any other data sets `fail`.
  - Once either flag is set, both freeze until reset; the first verdict wins.
  - The detector sees every store, including stores dropped on overflow.
  - Flags assert 1 cycle after the store edge.
- Not defined: `pass` and `fail` are tied to 0 and no comparator logic is synthesised. FIFO behaviour is identical in both builds.

## Test plan
- Reset, then 3 stores (addr 0x10/0x14/0x18, data 1/2/3) with `out_ready`=0 -> `count`=3, `out_valid`=1, head {0x10,1}. Raise `out_ready` -> records pop in order over 3 cycles, then `out_valid`=0.
- DEPTH=8: 10 back-to-back stores with `out_ready`=0 -> `count`=8, `overflow`=1, `drop_cnt`=2, and the FIFO holds stores 1..8.
- Full FIFO, store plus pop in the same cycle -> `count` stays 8, `drop_cnt` unchanged, and the new record appears last.
- 40 consecutive stores with `out_ready`=1 -> all 40 drained in order with `drop_cnt`=0, exercising pointer wrap.
- With the macro defined: store 7 to 84 -> `pass`=1 next cycle; then store 5 to 84 -> `fail` stays 0. In a fresh run, store 5 to 84 -> `fail`=1. Without the macro, both flags stay 0.
- Assert `rst`=0 with 5 records queued -> `count`=0 and `out_valid`=0 immediately, with no clock edge needed.
